// File: rtl/regfile_write_scheduler.sv
// Write-port arbiter and hazard scoreboard for the 16 x 32-bit register file.
// Build option: REGFILE_WRSCHED_BYPASS_EN lets Stall ignore a source being written this cycle.
module regfile_write_scheduler (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        alu_req,
  input  logic [3:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_gnt,
  input  logic        mem_req,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_gnt,
  input  logic        issue_valid,
  input  logic        issue_dst_en,
  input  logic [3:0]  issue_addr,
  input  logic        Rd1_en,
  input  logic        Rd2_en,
  input  logic [3:0]  Raddr1,
  input  logic [3:0]  Raddr2,
  output logic        Stall,
  output logic        RegWr,
  output logic [3:0]  Waddr,
  output logic [31:0] Writedata,
  output logic [15:0] busy
);

  // rr names the side that wins the next contested cycle (0 = ALU, 1 = MEM).
  logic        rr;
  logic        contested;
  logic        src1_hazard;
  logic        src2_hazard;
  logic        dst_hazard;
  logic        issue_accept;
  logic [15:0] busy_next;

  assign contested = alu_req & mem_req;
  assign alu_gnt   = RESET & alu_req & (~mem_req | ~rr);
  assign mem_gnt   = RESET & mem_req & (~alu_req |  rr);

`ifdef REGFILE_WRSCHED_BYPASS_EN
  // The register file writes on the negedge, so a source on the port now is readable by the next edge.
  assign src1_hazard = Rd1_en & busy[Raddr1] & ~(RegWr & (Waddr == Raddr1));
  assign src2_hazard = Rd2_en & busy[Raddr2] & ~(RegWr & (Waddr == Raddr2));
`else
  assign src1_hazard = Rd1_en & busy[Raddr1];
  assign src2_hazard = Rd2_en & busy[Raddr2];
`endif
  assign dst_hazard   = issue_dst_en & busy[issue_addr];
  assign Stall        = RESET & issue_valid & (src1_hazard | src2_hazard | dst_hazard);
  assign issue_accept = issue_valid & issue_dst_en & ~Stall;

  // Clear first, then set, so an issue landing on the register being written keeps it busy.
  always_comb begin
    busy_next = busy;
    if (RegWr)
      busy_next[Waddr] = 1'b0;
    if (issue_accept)
      busy_next[issue_addr] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RESET) begin
      rr        <= 1'b0;
      RegWr     <= 1'b0;
      Waddr     <= '0;
      Writedata <= '0;
      busy      <= '0;
    end else begin
      busy  <= busy_next;
      RegWr <= alu_gnt | mem_gnt;
      if (contested)
        rr <= ~rr;
      if (mem_gnt) begin
        Waddr     <= mem_addr;
        Writedata <= mem_data;
      end else if (alu_gnt) begin
        Waddr     <= alu_addr;
        Writedata <= alu_data;
      end
    end
  end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Write-port scheduler and hazard scoreboard for the 16 x 32-bit general-purpose register file. It shares the register file's single write port between two writeback requesters: ALU result and memory-load result. Conflicts are resolved round-robin, and the winning write is presented registered on RegWr/Waddr/Writedata. It also tracks registers with an outstanding write and raises a stall to the issue stage on read-after-write and write-after-write hazards.

## Interface
Parameters:
- None. Widths are fixed: 32-bit data, 4-bit register address, 16 registers.

Ports:
- CLK  in  1  clock. All state updates on posedge; the register file samples the write port on the following negedge.
- RESET  in  1  synchronous, active-low reset.
- alu_req  in  1  ALU writeback request.
- alu_addr  in  4  ALU destination register.
- alu_data  in  32  ALU result.
- alu_gnt  out  1  ALU request accepted this cycle (combinational).
- mem_req  in  1  load writeback request.
- mem_addr  in  4  load destination register.
- mem_data  in  32  load result.
- mem_gnt  out  1  load request accepted this cycle (combinational).
- issue_valid  in  1  issue stage presenting an instruction.
- issue_dst_en  in  1  the issuing instruction writes a register.
- issue_addr  in  4  destination of the issuing instruction.
- Rd1_en, Rd2_en  in  1 each  source operand used.
- Raddr1, Raddr2  in  4 each  source operand addresses (same values driven to the register file).
- Stall  out  1  issue must hold (combinational).
- RegWr  out  1  write enable to the register file (registered).
- Waddr  out  4  write address (registered).
- Writedata  out  32  write data (registered).
- busy  out  16  scoreboard vector; bit n set while register n has an outstanding write.

## Operation
- **Arbitration.** One grant per cycle.
  - Only one requester active: that requester is granted.
  - Both active: the requester selected by the 1-bit pointer `rr` (0 = ALU, 1 = MEM) is granted, and `rr` flips to the loser at the clock edge.
  - Uncontested grants leave `rr` unchanged.
  - A requester that is not granted holds req/addr/data stable until granted.
- **Write port.** On a granted edge, RegWr <= 1 and Waddr/Writedata <= the winner's addr/data. With no grant, RegWr <= 0 and Waddr/Writedata hold their previous values.
- **Scoreboard.**
  - Issue acceptance is `issue_valid & issue_dst_en & ~Stall`. On acceptance, busy[issue_addr] is set at the edge.
  - While RegWr = 1, busy[Waddr] is cleared at the edge that ends that cycle.
  - If a set and a clear hit the same bit at the same edge, the set wins.
  - A writeback to a non-busy register still writes; its scoreboard clear is a no-op.
- **Stall.** Stall = issue_valid & ((Rd1_en & busy[Raddr1]) | (Rd2_en & busy[Raddr2]) | (issue_dst_en & busy[issue_addr])).
- **Same destination from both requesters in one cycle.** Serialized by `rr`. The second write lands one cycle later and is the final register value.
- **Reset.** While RESET = 0:
  - alu_gnt = mem_gnt = 0 and Stall = 0.
  - At the edge: busy <= 0, rr <= 0, RegWr <= 0, Waddr <= 0, Writedata <= 0.
  - In-flight writes are dropped and requesters must re-request.

## Timing
- Grant to register-file write: the grant is at edge E. RegWr is high during cycle E..E+1, and the register file writes at the negedge inside that cycle.
- busy clears at E+1. A dependent instruction issues no earlier than the cycle after E+1, unless the bypass feature is compiled in.
- Issue to busy visible: one edge. The Stall seen by the next instruction reflects it in the following cycle.
- Maximum throughput: one write per cycle. With both requesters continuously active, grants alternate ALU, MEM, ALU, …

## Configuration
- `REGFILE_WRSCHED_BYPASS_EN`
  - **Defined:** Stall ignores a busy source register whose write is on the port this cycle (RegWr = 1 and Waddr == Raddr1/Raddr2). The register file's negedge write makes the new value readable before the next posedge. The WAW term is not bypassed.
  - **Undefined:** Stall exactly as given in Operation, with one extra bubble per dependency.

## Test plan
- **Reset:** hold RESET = 0 for 2 cycles with both requesters active -> no grants; RegWr = 0, Waddr = 0, Writedata = 0, busy = 16'h0000.
- **Single write:** alu_req with addr 3, data 32'h0000_00AA -> alu_gnt = 1 that cycle; next cycle RegWr = 1, Waddr = 3, Writedata = 32'hAA.
- **Contention:** both requesters held active for 4 cycles (ALU addr 1, MEM addr 2) from reset -> grant order ALU, MEM, ALU, MEM; Waddr sequence 1, 2, 1, 2.
- **RAW stall:** issue with dst 5 accepted -> busy = 16'h0020; next instruction with Raddr1 = 5 gets Stall = 1 until busy[5] clears after a write to 5, then Stall = 0.
  - With `REGFILE_WRSCHED_BYPASS_EN` defined, Stall drops one cycle earlier.
- **Set/clear collision:** write to register 7 on the port while an issue with dst 7 is accepted in the same cycle -> busy[7] remains 1.
- **Reset mid-operation:** MEM denied (`rr` = 0, both requesting) and busy = 16'h0081, then RESET = 0 for 1 cycle -> busy = 0, RegWr = 0, rr = 0; after reset the ALU is granted first on contention.
